// File: rtl/mpd_cfg_bitbang_loader.sv
// mpd_cfg_bitbang_loader: sync/deserialise bit-banged s_clk/s_data, validate sync/len/payload/checksum frame, emit write strobes
module mpd_cfg_bitbang_loader #(
  parameter logic [31:0] SYNC_WORD      = 32'hFAB0_FAB1,
  parameter logic [15:0] MAX_WORDS      = 16'd4096,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        s_clk,
  input  logic        s_data,
  output logic [31:0] write_data,
  output logic        write_strobe,
  output logic [15:0] word_count,
  output logic        busy,
  output logic        done,
  output logic        error
);
  localparam logic [1:0] S_HUNT = 2'd0, S_LEN = 2'd1, S_DATA = 2'd2, S_CHECK = 2'd3;
  logic [2:0]  sclk_q, sclk_d;
  logic [1:0]  sdat_q, sdat_d;
  logic [1:0]  state_q, state_d;
  logic [31:0] shift_q, shift_d, cksum_q, cksum_d, wdata_q, wdata_d, word;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic [23:0] tmo_q, tmo_d;
  logic [15:0] len_q, len_d, wc_q, wc_d;
  logic        stb_q, stb_d, done_q, done_d, err_q, err_d;
  logic        rise, in_frame, word_done, timeout;
  always_comb begin
    sclk_d    = {sclk_q[1:0], s_clk};
    sdat_d    = {sdat_q[0], s_data};
    rise      = sclk_q[1] & ~sclk_q[2];
    word      = {shift_q[30:0], sdat_q[1]};
    in_frame  = state_q != S_HUNT;
    word_done = rise && in_frame && bitcnt_q == 5'd31;
    timeout   = in_frame && !rise && tmo_q == TIMEOUT_CYCLES - 24'd1;
    state_d   = state_q;
    shift_d   = rise ? word : shift_q;
    bitcnt_d  = (rise && in_frame) ? bitcnt_q + 5'd1 : bitcnt_q;
    tmo_d     = (!in_frame || rise) ? 24'd0 : tmo_q + 24'd1;
    len_d     = len_q;
    cksum_d   = cksum_q;
    wdata_d   = wdata_q;
    stb_d     = 1'b0;
    wc_d      = wc_q;
    done_d    = done_q;
    err_d     = err_q;
    if (!enable) begin
      state_d  = S_HUNT;
      shift_d  = '0;
      bitcnt_d = '0;
      tmo_d    = '0;
    end else if (timeout) begin
      err_d   = 1'b1;
      state_d = S_HUNT;
    end else if (state_q == S_HUNT) begin
      if (rise && word == SYNC_WORD) begin
        state_d  = S_LEN;
        done_d   = 1'b0;
        err_d    = 1'b0;
        wc_d     = '0;
        cksum_d  = '0;
        bitcnt_d = '0;
      end
    end else if (word_done) begin
      if (state_q == S_LEN) begin
        len_d = word[15:0];
        if (word[31:16] != 16'd0 || word[15:0] > MAX_WORDS) begin
          err_d   = 1'b1;
          state_d = S_HUNT;
        end else
          state_d = (word[15:0] == 16'd0) ? S_CHECK : S_DATA;
      end else if (state_q == S_DATA) begin
        wdata_d = word;
        stb_d   = 1'b1;
        wc_d    = wc_q + 16'd1;
        cksum_d = cksum_q + word;
        state_d = (wc_q + 16'd1 == len_q) ? S_CHECK : S_DATA;
      end else begin
        done_d  = word == cksum_q;
        err_d   = word != cksum_q;
        state_d = S_HUNT;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_q   <= '0;
      sdat_q   <= '0;
      state_q  <= S_HUNT;
      shift_q  <= '0;
      bitcnt_q <= '0;
      tmo_q    <= '0;
      len_q    <= '0;
      cksum_q  <= '0;
      wdata_q  <= '0;
      stb_q    <= 1'b0;
      wc_q     <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sclk_q   <= sclk_d;
      sdat_q   <= sdat_d;
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      tmo_q    <= tmo_d;
      len_q    <= len_d;
      cksum_q  <= cksum_d;
      wdata_q  <= wdata_d;
      stb_q    <= stb_d;
      wc_q     <= wc_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end
  assign write_data   = wdata_q;
  assign write_strobe = stb_q;
  assign word_count   = wc_q;
  assign busy         = state_q != S_HUNT;
  assign done         = done_q;
  assign error        = err_q;
endmodule

// File: doc/mpd_cfg_bitbang_loader.md
# mpd_cfg_bitbang_loader

Upstream configuration front-end for the eFPGA fabric. Synchronises the bit-banged `s_clk`/`s_data` pad pair and deserialises the stream into 32-bit words. Validates a framed bitstream (sync word, length, payload, checksum) and presents each payload word as a one-cycle write strobe plus data. These outputs drive the fabric's `SelfWriteStrobe`/`SelfWriteData` port. It also reports busy/done/error status for the board LEDs.

## Interface
- `SYNC_WORD`, 32'hFAB0_FAB1: frame start marker.
- `MAX_WORDS`, 16'd4096: largest accepted payload length.
- `TIMEOUT_CYCLES`, 24'd1_000_000: idle `clk` cycles tolerated between `s_clk` rising edges inside a frame.

- `clk` in 1: fabric clock.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: loader enable. Low aborts to HUNT.
- `s_clk` in 1: bit-bang serial clock, asynchronous to `clk`.
- `s_data` in 1: bit-bang serial data, asynchronous to `clk`, MSB first.
- `write_data` out 32: payload word, valid when `write_strobe` is high.
- `write_strobe` out 1: one-cycle pulse per payload word.
- `word_count` out 16: payload words emitted in the current or last frame.
- `busy` out 1: high in LEN, DATA and CHECK.
- `done` out 1: sticky; frame received with a correct checksum.
- `error` out 1: sticky; length, checksum or timeout failure.

## Operation
- **Input synchronisation:** `s_clk` and `s_data` each pass through two flops.
- **Edge detection:** a third flop on `s_clk` detects rising edges. On each rising edge, the synchronised `s_data` is shifted into a 32-bit register at bit 0, and prior contents shift left.
- **States:** HUNT, LEN, DATA, CHECK.
- **HUNT**
  - Sliding compare after every shifted bit. When the shift register equals `SYNC_WORD` → LEN.
  - Entering LEN clears `done`, `error`, `word_count`, the checksum accumulator and the bit counter.
- **Bit counting:** in LEN, DATA and CHECK, a 5-bit counter counts shifted bits. The 32nd bit completes a word and the counter wraps to 0.
- **LEN**
  - On word complete, latch length `N` = word[15:0].
  - If word[31:16] ≠ 0 or `N` > `MAX_WORDS`: set `error` → HUNT.
  - If `N` = 0 → CHECK.
  - Otherwise → DATA.
- **DATA**
  - On each complete word: drive `write_data` with the word and pulse `write_strobe`.
  - Increment `word_count`.
  - Update checksum as `checksum + word` mod 2^32.
  - After the `N`th word → CHECK.
- **CHECK**
  - On word complete: if word == checksum, set `done`; else set `error`. Either way → HUNT.
- **Timeout**
  - A 24-bit counter clears on every `s_clk` rising edge and whenever the state is HUNT.
  - In LEN, DATA and CHECK, reaching `TIMEOUT_CYCLES` sets `error` → HUNT.
- **`enable` low**
  - Forces HUNT and clears the shift register and bit counter.
  - Suppresses `write_strobe`.
  - `done`, `error` and `word_count` hold their values.
- **Flags:** `done` and `error` are never both high. Each is cleared only by `reset` or by the next sync detection.
- **Wrap rules:** all counters saturate-free. `word_count` cannot exceed `MAX_WORDS` by construction.

## Timing
- **Reset values:** all outputs 0; state HUNT; shift register, checksum and counters 0; sync flops 0.
- **Pad timing:** `s_clk` high and low phases must each be ≥ 3 `clk` cycles. `s_data` must be stable for ≥ 3 cycles around the `s_clk` rising edge.
- **Edge latency:** the edge is detected 3 `clk` cycles after the pad `s_clk` rise (2 sync + 1 edge flop). The bit shifts in that same cycle.
- **Strobe latency:** `write_strobe` and `write_data` are registered, asserting the cycle after the 32nd-bit shift. `write_strobe` is high for exactly 1 cycle.
- **Data hold:** `write_data` holds its value until the next strobe.
- **Flag latency:** `done` or `error` assert the cycle after the final bit shift, in the same cycle the state returns to HUNT. `busy` falls in that same cycle.
- **Sync detection:** sync detection to `busy` high takes 1 cycle.
- **Reset precedence:** `reset` overrides everything.
- **Precedence when `enable` is high:** a timeout and an edge in the same cycle resolve as the edge (the counter clears, no error).
- **Precedence between `reset` and `enable`:** reset mid-frame behaves as full reset. `enable` low mid-frame behaves as the abort rules in Operation.

## Test plan
- **Good frame:**
  - Stimulus: sync, then length 3, then data 0x11111111, 0x22222222, 0x33333333, then checksum 0x66666666.
  - Response: three strobes carrying those words in order, `word_count` 3, `done` 1, `error` 0, `busy` 0.
- **Bad checksum:**
  - Stimulus: same frame with checksum 0x66666667.
  - Response: three strobes still emitted, then `error` 1 and `done` 0.
  - Follow-up: a following good frame clears `error` at sync and ends with `done` 1.
- **Length violations:**
  - Stimulus: length word 0x00011000 (upper half nonzero), then a separate frame with length 4097.
  - Response: `error` 1 after the length word in each case, zero strobes, back in HUNT.
- **Zero length and noise:**
  - Stimulus: 40 random bits with no sync pattern, then sync, length 0, checksum 0x00000000.
  - Response: no `busy` during the noise, `done` 1, no strobes.
- **Timeout:**
  - Stimulus: with `TIMEOUT_CYCLES` = 100, send sync, length 2 and 10 bits of data, then stop `s_clk`.
  - Response: `error` 1 exactly 100 cycles after the last detected edge, `word_count` 0.
- **Abort and reset mid-frame:**
  - Stimulus: deassert `enable` after the first data word; later assert `reset` during another frame.
  - Response: on `enable` low, HUNT with `word_count` 1 and flags held. On `reset`, all outputs 0 the next cycle.
